// File: rtl/upsample_pkg.sv
// Shared definitions for the upsample layer scheduler: the layer table
// (channel counts, size codes, input pixel counts), field widths and the
// scheduler state encoding.
package upsample_pkg;

  localparam int unsigned LAYER_W          = 3;
  localparam int unsigned SIZE_W           = 3;
  localparam int unsigned PIX_IN_W         = 15;
  localparam int unsigned PIX_OUT_W        = 17;
  localparam int unsigned NUM_TABLE_LAYERS = 6;

  localparam int unsigned LAYER_CHANNELS [NUM_TABLE_LAYERS] =
    '{256, 256, 256, 256, 128, 64};

  localparam logic [SIZE_W-1:0] LAYER_SIZE [NUM_TABLE_LAYERS] =
    '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

  localparam logic [PIX_IN_W-1:0] LAYER_PIXELS_IN [NUM_TABLE_LAYERS] =
    '{15'd16, 15'd64, 15'd256, 15'd1024, 15'd4096, 15'd16384};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DRAIN
  } sched_state_t;

  // 2x upsample in both dimensions: four output pixels per input pixel.
  function automatic logic [PIX_OUT_W-1:0] pixels_out(input logic [PIX_IN_W-1:0] pix_in);
    return {pix_in, 2'b00};
  endfunction

endpackage

// File: rtl/upsample_layer_rom.sv
// Combinational layer table lookup indexed by layer number. Out-of-table
// indices return all zeros.
module upsample_layer_rom
  import upsample_pkg::*;
#(
  parameter int CH_W = 9
) (
  input  logic [LAYER_W-1:0]  layer,
  output logic [CH_W-1:0]     last_channel,
  output logic [SIZE_W-1:0]   size,
  output logic [PIX_IN_W-1:0] pixels_in
);

  // Table lookup; last_channel is the channel count minus one.
  always_comb begin
    last_channel = '0;
    size         = '0;
    pixels_in    = '0;
    if (int'(layer) < int'(NUM_TABLE_LAYERS)) begin
      last_channel = CH_W'(LAYER_CHANNELS[layer] - 1);
      size         = LAYER_SIZE[layer];
      pixels_in    = LAYER_PIXELS_IN[layer];
    end
  end

endmodule

// File: rtl/upsample_layer_scheduler.sv
// Upsample layer scheduler: walks layers first_layer..last_layer and, per
// layer, issues one job per channel to the upsample engine with a
// valid/ready handshake, waiting for job_done between jobs. Supports abort
// with drain of an outstanding job.
// Optional feature: define UPSAMPLE_SCHED_PERF_EN to add the 32-bit
// perf_cycles busy-cycle counter output.
module upsample_layer_scheduler
  import upsample_pkg::*;
#(
  parameter int NUM_LAYERS = 6,
  parameter int CH_W       = 9
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LAYER_W-1:0]   first_layer,
  input  logic [LAYER_W-1:0]   last_layer,
  output logic                 job_valid,
  input  logic                 job_ready,
  output logic [LAYER_W-1:0]   job_layer,
  output logic [SIZE_W-1:0]    job_size,
  output logic [CH_W-1:0]      job_channel,
  output logic [PIX_IN_W-1:0]  job_pixels_in,
  output logic [PIX_OUT_W-1:0] job_pixels_out,
  input  logic                 job_done,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 all_done,
  output logic                 cfg_err,
`ifdef UPSAMPLE_SCHED_PERF_EN
  output logic                 err_spurious,
  output logic [31:0]          perf_cycles
`else
  output logic                 err_spurious
`endif
);

  sched_state_t         state_q, state_d;
  logic [LAYER_W-1:0]   layer_q, layer_d;
  logic [LAYER_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]      channel_q, channel_d;
  logic                 pending_q, pending_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 err_q;
  logic                 layer_done_c, all_done_c;
  logic                 range_ok;
  logic                 start_ok;

  logic [CH_W-1:0]      rom_last_channel;
  logic [SIZE_W-1:0]    rom_size;
  logic [PIX_IN_W-1:0]  rom_pixels_in;

  upsample_layer_rom #(
    .CH_W (CH_W)
  ) u_rom (
    .layer        (layer_q),
    .last_channel (rom_last_channel),
    .size         (rom_size),
    .pixels_in    (rom_pixels_in)
  );

  assign range_ok = (first_layer <= last_layer) && (int'(last_layer) < NUM_LAYERS);
  assign start_ok = (state_q == S_IDLE) && start && range_ok;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      layer_q   <= '0;
      last_q    <= '0;
      channel_q <= '0;
      pending_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      last_q    <= last_d;
      channel_q <= channel_d;
      pending_q <= pending_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Sticky flag for job_done arriving when no job can be outstanding.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if (job_done && (state_q != S_WAIT) && (state_q != S_DRAIN)) begin
      err_q <= 1'b1;
    end
  end

  // Next-state logic and completion pulses.
  // Abort outranks job_ready/job_done in the same cycle; a handshake that
  // coincides with abort leaves a job outstanding, so it is drained.
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    last_d       = last_q;
    channel_d    = channel_q;
    pending_d    = pending_q;
    cfg_err_d    = 1'b0;
    layer_done_c = 1'b0;
    all_done_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (range_ok) begin
            layer_d   = first_layer;
            last_d    = last_layer;
            channel_d = '0;
            state_d   = S_ISSUE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (abort) begin
          if (job_ready) begin
            pending_d = 1'b1;
            state_d   = S_DRAIN;
          end else begin
            state_d   = S_IDLE;
          end
        end else if (job_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          pending_d = !job_done;
          state_d   = S_DRAIN;
        end else if (job_done) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (abort) begin
          pending_d = 1'b0;
          state_d   = S_DRAIN;
        end else if (channel_q != rom_last_channel) begin
          channel_d = channel_q + CH_W'(1);
          state_d   = S_ISSUE;
        end else begin
          layer_done_c = 1'b1;
          if (layer_q == last_q) begin
            all_done_c = 1'b1;
            state_d    = S_IDLE;
          end else begin
            layer_d   = layer_q + LAYER_W'(1);
            channel_d = '0;
            state_d   = S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (!pending_q || job_done) begin
          pending_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output drive; everything is held at zero while reset is asserted and
  // job fields read zero whenever no job is offered.
  always_comb begin
    job_valid      = aresetn && (state_q == S_ISSUE);
    busy           = aresetn && (state_q != S_IDLE);
    layer_done     = aresetn && layer_done_c;
    all_done       = aresetn && all_done_c;
    cfg_err        = aresetn && cfg_err_q;
    err_spurious   = aresetn && err_q;
    job_layer      = '0;
    job_size       = '0;
    job_channel    = '0;
    job_pixels_in  = '0;
    job_pixels_out = '0;
    if (job_valid) begin
      job_layer      = layer_q;
      job_size       = rom_size;
      job_channel    = channel_q;
      job_pixels_in  = rom_pixels_in;
      job_pixels_out = pixels_out(rom_pixels_in);
    end
  end

`ifdef UPSAMPLE_SCHED_PERF_EN
  // Busy-cycle counter: cleared by an accepted start, saturating.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      perf_cycles <= '0;
    end else if (start_ok) begin
      perf_cycles <= '0;
    end else if ((state_q != S_IDLE) && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_upsample_layer_scheduler.sv
// Directed self-checking bench for upsample_layer_scheduler. Acts as the
// upsample engine; inputs change on the falling edge, outputs are sampled
// on the falling edge. Define UPSAMPLE_SCHED_PERF_EN to cover perf_cycles.
module tb_upsample_layer_scheduler;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        start;
  logic        abort;
  logic [2:0]  first_layer;
  logic [2:0]  last_layer;
  logic        job_valid;
  logic        job_ready;
  logic [2:0]  job_layer;
  logic [2:0]  job_size;
  logic [8:0]  job_channel;
  logic [14:0] job_pixels_in;
  logic [16:0] job_pixels_out;
  logic        job_done;
  logic        busy;
  logic        layer_done;
  logic        all_done;
  logic        cfg_err;
  logic        err_spurious;
`ifdef UPSAMPLE_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  upsample_layer_scheduler #(
    .NUM_LAYERS (6),
    .CH_W       (9)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .start          (start),
    .abort          (abort),
    .first_layer    (first_layer),
    .last_layer     (last_layer),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_layer      (job_layer),
    .job_size       (job_size),
    .job_channel    (job_channel),
    .job_pixels_in  (job_pixels_in),
    .job_pixels_out (job_pixels_out),
    .job_done       (job_done),
    .busy           (busy),
    .layer_done     (layer_done),
    .all_done       (all_done),
    .cfg_err        (cfg_err),
`ifdef UPSAMPLE_SCHED_PERF_EN
    .err_spurious   (err_spurious),
    .perf_cycles    (perf_cycles)
`else
    .err_spurious   (err_spurious)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int tb_ch  [6] = '{256, 256, 256, 256, 128, 64};
  int tb_pix [6] = '{16, 64, 256, 1024, 4096, 16384};

  // results of the most recent stream run
  int jobs, field_errs, ld_cnt, ad_cnt, busy_cnt;
  int last_ch_seen, last_pin, last_pout;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Engine model: job_ready tied high, job_done three cycles after each
  // handshake. Stops after all_done, or right after the handshake of
  // channel stop_ch. A start pulse is injected on the handshake of
  // channel inject_ch to prove starts are ignored while busy.
  task automatic stream(input int first, input int last, input int stop_ch,
                        input int inject_ch, input int bound);
    int lay = first;
    int ch  = 0;
    int cnt = 0;
    bit finished = 0;
    jobs = 0; field_errs = 0; ld_cnt = 0; ad_cnt = 0; busy_cnt = 0;
    job_ready = 1'b1;
    for (int cyc = 0; cyc < bound && !finished; cyc++) begin
      @(negedge clk);
      start    = 1'b0;
      job_done = 1'b0;
      if (busy) busy_cnt++;
      if (layer_done) ld_cnt++;
      if (all_done) begin
        ad_cnt++;
        if (!layer_done) field_errs++;
        finished = 1;
      end
      if (job_valid && job_ready) begin
        jobs++;
        if (lay > last) begin
          field_errs++;
        end else if (job_layer !== 3'(lay) || job_size !== 3'(lay) ||
                     job_channel !== 9'(ch) || job_pixels_in !== 15'(tb_pix[lay]) ||
                     job_pixels_out !== 17'(tb_pix[lay] * 4)) begin
          field_errs++;
        end
        last_ch_seen = int'(job_channel);
        last_pin     = int'(job_pixels_in);
        last_pout    = int'(job_pixels_out);
        if (ch == stop_ch) return;
        if (ch == inject_ch) begin
          start = 1'b1; first_layer = 3'd0; last_layer = 3'd0;
        end
        ch++;
        if (lay <= last && ch == tb_ch[lay]) begin
          ch = 0;
          lay++;
        end
        cnt = 3;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) job_done = 1'b1;
      end
    end
    if (!finished) chk("stream timeout", 64'(finished), 64'd1);
  endtask

  task automatic kick(input logic [2:0] f, input logic [2:0] l);
    @(negedge clk);
    start = 1'b1; first_layer = f; last_layer = l;
  endtask

  logic [63:0] snap;
  int diffs, cnt_a, cnt_b;

  initial begin
    aresetn = 1'b0; start = 1'b0; abort = 1'b0; first_layer = '0; last_layer = '0;
    job_ready = 1'b0; job_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs",
        {job_valid, busy, layer_done, all_done, cfg_err, err_spurious, job_layer,
         job_size, job_channel, job_pixels_in, job_pixels_out}, 64'd0);
    aresetn = 1'b1;

    // single layer L0
    kick(3'd0, 3'd0);
    stream(0, 0, -1, -1, 3000);
    chk("l0 jobs", 64'(jobs), 64'd256);
    chk("l0 fields", 64'(field_errs), 64'd0);
    chk("l0 layer_done", 64'(ld_cnt), 64'd1);
    chk("l0 all_done", 64'(ad_cnt), 64'd1);
    chk("l0 busy cycles", 64'(busy_cnt), 64'd1280);
    @(negedge clk);
    chk("l0 busy after", 64'(busy), 64'd0);

    // single layer L5
    kick(3'd5, 3'd5);
    stream(5, 5, -1, -1, 1000);
    chk("l5 jobs", 64'(jobs), 64'd64);
    chk("l5 fields", 64'(field_errs), 64'd0);
    chk("l5 last channel", 64'(last_ch_seen), 64'd63);
    chk("l5 pixels_in", 64'(last_pin), 64'd16384);
    chk("l5 pixels_out", 64'(last_pout), 64'd65536);
    chk("l5 busy cycles", 64'(busy_cnt), 64'd320);
    @(negedge clk);
    chk("l5 busy after", 64'(busy), 64'd0);
`ifdef UPSAMPLE_SCHED_PERF_EN
    chk("perf after l5", 64'(perf_cycles), 64'(busy_cnt));
    kick(3'd5, 3'd5);
    @(negedge clk);
    start = 1'b0;
    chk("perf cleared", 64'(perf_cycles), 64'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`endif

    // backpressure on L2, then abort from ISSUE
    job_ready = 1'b0;
    kick(3'd2, 3'd2);
    @(negedge clk);
    start = 1'b0;
    chk("bp valid", 64'(job_valid), 64'd1);
    snap = {job_layer, job_size, job_channel, job_pixels_in, job_pixels_out};
    chk("bp fields", snap, {3'd2, 3'd2, 9'd0, 15'd256, 17'd1024});
    diffs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!job_valid || {job_layer, job_size, job_channel, job_pixels_in, job_pixels_out} !== snap)
        diffs++;
    end
    chk("bp stable", 64'(diffs), 64'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("issue abort valid", 64'(job_valid), 64'd0);
    chk("issue abort busy", 64'(busy), 64'd0);

    // invalid range
    kick(3'd3, 3'd2);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (cfg_err) cnt_a++;
      if (job_valid || busy) cnt_b++;
    end
    chk("cfg_err pulses", 64'(cnt_a), 64'd1);
    chk("cfg_err no job", 64'(cnt_b), 64'd0);

    // abort in WAIT on L1 channel 10, with a start injected while busy
    kick(3'd1, 3'd1);
    stream(1, 1, 10, 5, 200);
    chk("abort jobs", 64'(jobs), 64'd11);
    chk("abort fields", 64'(field_errs), 64'd0);
    @(negedge clk);
    chk("abort in wait", 64'(busy && !job_valid), 64'd1);
    abort = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      abort = 1'b0;
      if (!busy || job_valid) cnt_a++;
      if (layer_done || all_done) cnt_b++;
    end
    chk("drain holds", 64'(cnt_a), 64'd0);
    job_done = 1'b1;
    @(negedge clk);
    job_done = 1'b0;
    if (layer_done || all_done) cnt_b++;
    chk("drain exit busy", 64'(busy), 64'd0);
    @(negedge clk);
    if (layer_done || all_done) cnt_b++;
    chk("abort no done pulses", 64'(cnt_b + ld_cnt + ad_cnt), 64'd0);

    // spurious job_done in IDLE
    chk("err clear before", 64'(err_spurious), 64'd0);
    job_done = 1'b1;
    @(negedge clk);
    job_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("err sticky", 64'(err_spurious), 64'd1);

    // reset in the middle of WAIT
    kick(3'd0, 3'd0);
    stream(0, 0, 0, -1, 20);
    @(negedge clk);
    chk("pre-reset in wait", 64'(busy), 64'd1);
    aresetn = 1'b0;
    @(negedge clk);
    chk("reset mid wait",
        {job_valid, busy, layer_done, all_done, cfg_err, err_spurious, job_layer,
         job_size, job_channel, job_pixels_in, job_pixels_out}, 64'd0);
    aresetn = 1'b1;
    job_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("after reset idle", 64'({busy, err_spurious, layer_done, all_done}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/upsample_layer_scheduler.md
UPSAMPLE_LAYER_SCHEDULER -- requirements
Module: upsample_layer_scheduler

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 6, giving the number of entries in the layer table.
REQ-002 SHALL have parameter CH_W, default 9, giving the channel counter width.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: run request pulse.
REQ-006 SHALL have port abort, input, 1 bit: cancel request.
REQ-007 SHALL have port first_layer, input, 3 bits: first layer index to run.
REQ-008 SHALL have port last_layer, input, 3 bits: last layer index to run.
REQ-009 SHALL have port job_valid, output, 1 bit: per-channel job offered to the upsample engine.
REQ-010 SHALL have port job_ready, input, 1 bit: engine accepts the job.
REQ-011 SHALL have port job_layer, output, 3 bits; job_size, output, 3 bits; job_channel, output, CH_W bits.
REQ-012 SHALL have port job_pixels_in, output, 15 bits; job_pixels_out, output, 17 bits.
REQ-013 SHALL have port job_done, input, 1 bit: engine finished the outstanding job.
REQ-014 SHALL have outputs busy (level), layer_done (pulse), all_done (pulse), cfg_err (pulse) and err_spurious (sticky), each 1 bit.

Function
REQ-015 SHALL use layer table L0..L5: channels 256,256,256,256,128,64; size codes 0..5; pixels_in 16,64,256,1024,4096,16384.
REQ-016 SHALL drive job_pixels_out as job_pixels_in shifted left by 2, zero-extended with no truncation.
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, NEXT, DRAIN.
REQ-018 SHALL, on start in IDLE with first_layer<=last_layer<=5: latch both, set layer=first_layer and channel=0, and enter ISSUE.
REQ-019 SHALL, on start in IDLE with an invalid range: pulse cfg_err for one cycle, stay in IDLE, and issue no job.
REQ-020 SHALL assert job_valid exactly while in ISSUE, with the first job_valid one cycle after the accepted start.
REQ-021 SHALL hold job_* fields stable while job_valid is high and job_ready is low.
REQ-022 SHALL treat job_valid&&job_ready as the handshake and move to WAIT on it.
REQ-023 SHALL, on job_done in WAIT, enter NEXT, so the next job_valid appears two cycles after job_done.
REQ-024 SHALL, in NEXT with channel<channels-1: increment channel and return to ISSUE.
REQ-025 SHALL, in NEXT with the last channel: pulse layer_done; then, if layer==last_layer, pulse all_done in the same cycle and go to IDLE; else increment layer, clear channel and go to ISSUE.
REQ-026 SHALL hold busy high in every state except IDLE.
REQ-027 SHALL ignore start when busy is high.
REQ-028 SHALL, on abort in ISSUE, deassert job_valid next cycle and go to IDLE.
REQ-029 SHALL, on abort in WAIT or NEXT, go to DRAIN, wait for job_done if a job is outstanding, then go to IDLE.
REQ-030 SHALL NOT pulse layer_done or all_done on any aborted path.
REQ-031 SHALL give abort priority over job_ready and job_done arriving in the same cycle; a handshake in that cycle counts as outstanding.
REQ-032 SHALL set err_spurious on job_done outside WAIT/DRAIN, and clear it only on reset.

Reset
REQ-033 SHALL, while aresetn is low, force state IDLE, all counters 0, and outputs job_valid, busy, layer_done, all_done, cfg_err, err_spurious and job_* to 0.
REQ-034 SHALL, on reset mid-job, abandon the job without drain and pulse nothing.

Configuration
REQ-035 SHALL, with UPSAMPLE_SCHED_PERF_EN defined, add output perf_cycles (32 bits) that counts cycles with busy high, clears on accepted start, saturates at all-ones and resets to 0.
REQ-036 SHALL, without UPSAMPLE_SCHED_PERF_EN, omit the perf_cycles port and its logic, with all other behaviour identical.

Structure
REQ-037 SHALL place the layer table constants, size codes, state encoding and pixel widths in shared package upsample_pkg.
REQ-038 SHALL implement the table lookup as combinational sub-module upsample_layer_rom, indexed by layer.

Verification
REQ-039 SHALL cover: first=last=0, job_ready tied 1, job_done 3 cycles after each handshake -> 256 jobs with sizes 16/64, one layer_done and one all_done on the same cycle, then busy=0.
REQ-040 SHALL cover: first=5, last=5 -> 64 jobs, job_pixels_in=16384, job_pixels_out=65536, job_channel 0..63 in order.
REQ-041 SHALL cover: job_ready held low 10 cycles -> job_* unchanged throughout; first=3, last=2 -> single cfg_err pulse and no job_valid.
REQ-042 SHALL cover: abort in WAIT on channel 10 of L1 -> DRAIN until job_done, then IDLE, no layer_done or all_done; start during busy ignored.
REQ-043 SHALL cover: job_done in IDLE -> err_spurious=1 until aresetn; reset mid-WAIT -> all outputs 0 the next cycle.
REQ-044 SHALL cover, with UPSAMPLE_SCHED_PERF_EN: L5-only run -> perf_cycles equals the counted busy cycles and clears on the next start.
